// File: rtl/dm_pkg.sv
// ---------------------------------------------------------------------------
// dm_pkg
// Shared definitions for the data-memory access unit:
//   - DMType access codes, also used by the instruction decoder
//   - access unit state encoding
//   - helpers for the alignment/type check, load extension and store merge
// ---------------------------------------------------------------------------
package dm_pkg;

    localparam logic [2:0] DM_WORD   = 3'b000;
    localparam logic [2:0] DM_HALF   = 3'b001;
    localparam logic [2:0] DM_HALF_U = 3'b010;
    localparam logic [2:0] DM_BYTE   = 3'b011;
    localparam logic [2:0] DM_BYTE_U = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LD   = 2'd1,
        ST_RMW  = 2'd2,
        ST_RESP = 2'd3
    } dm_state_t;

    // Misaligned word/half accesses and the unused codes 101..111 are errors.
    function automatic logic access_error(input logic [2:0] dm_type,
                                          input logic [1:0] off);
        logic err;
        case (dm_type)
            DM_WORD:            err = (off != 2'b00);
            DM_HALF, DM_HALF_U: err = off[0];
            DM_BYTE, DM_BYTE_U: err = 1'b0;
            default:            err = 1'b1;
        endcase
        return err;
    endfunction

    // Pick the addressed byte/half out of a RAM word and extend it.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [2:0]  dm_type,
                                                input logic [1:0]  off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[8*off +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (dm_type)
            DM_HALF:   r = {{16{h[15]}}, h};
            DM_HALF_U: r = {16'h0000, h};
            DM_BYTE:   r = {{24{b[7]}}, b};
            DM_BYTE_U: r = {24'h000000, b};
            default:   r = word;
        endcase
        return r;
    endfunction

    // Insert the low byte/half of the store data into the addressed lane,
    // leaving the other lanes of the old word untouched.
    function automatic logic [31:0] store_merge(input logic [31:0] old_word,
                                                input logic [15:0] wdata,
                                                input logic [2:0]  dm_type,
                                                input logic [1:0]  off);
        logic [31:0] r;
        r = old_word;
        case (dm_type)
            DM_BYTE, DM_BYTE_U: r[8*off +: 8] = wdata[7:0];
            DM_HALF, DM_HALF_U: begin
                if (off[1]) r[31:16] = wdata;
                else        r[15:0]  = wdata;
            end
            default: r = old_word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dm_ram.sv
// ---------------------------------------------------------------------------
// dm_ram
// Single-port synchronous word RAM, 2**ADDR_W x 32, one-cycle read latency.
// Contents are not reset.
// Ports:
//   clk  - rising-edge clock
//   we   - write enable for word idx
//   idx  - word index (read and write share it)
//   din  - write data
//   dout - read data for the idx presented on the previous edge
// ---------------------------------------------------------------------------
module dm_ram #(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] idx,
    input  logic [31:0]       din,
    output logic [31:0]       dout
);

    logic [31:0] mem [2**ADDR_W];

    // Read returns the word as it was before a same-edge write.
    always_ff @(posedge clk) begin
        if (we) mem[idx] <= din;
        dout <= mem[idx];
    end

endmodule

// File: rtl/dm_access_unit.sv
// ---------------------------------------------------------------------------
// dm_access_unit
// Data-memory responder for the RISC-V core. Executes word/half/byte loads
// and stores against a word RAM without byte enables; sub-word stores are
// done as read-modify-write, loads are sign- or zero-extended.
// Ports:
//   clk, rstn   - clock, asynchronous active-low reset
//   req_valid   - access request
//   req_ready   - unit idle, request accepted this cycle if req_valid
//   mem_write   - 1 store, 0 load
//   dm_type     - DMType access code
//   addr        - byte address (word index wraps modulo RAM size)
//   wdata       - store data
//   rsp_valid   - one-cycle completion pulse
//   rsp_rdata   - extended load data, 0 for stores and errors
//   rsp_err     - misaligned access or illegal dm_type
// ---------------------------------------------------------------------------
module dm_access_unit
    import dm_pkg::*;
#(
    parameter int ADDR_W = 7
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        mem_write,
    input  logic [2:0]  dm_type,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    dm_state_t         state;
    dm_state_t         state_next;
    logic              accept;
    logic              acc_err;
    logic              ram_we_raw;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_idx;
    logic [31:0]       ram_din;
    logic [31:0]       ram_dout;

    logic [2:0]        req_type_q;
    logic [1:0]        req_off_q;
    logic [ADDR_W-1:0] req_idx_q;
    logic [15:0]       req_wdata_q;

    logic              unused_addr_hi;
    assign unused_addr_hi = ^addr[31:ADDR_W+2];

    assign acc_err = access_error(dm_type, addr[1:0]);

    // Gate writes while reset is held so an aborted RMW never lands in RAM.
    assign ram_we = ram_we_raw & rstn;

    dm_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .idx  (ram_idx),
        .din  (ram_din),
        .dout (ram_dout)
    );

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next state, handshake and RAM control. In IDLE the RAM is addressed
    // straight from the request so loads and RMW reads start in the accept
    // cycle; in RMW it uses the captured index and writes the merged word.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        accept     = 1'b0;
        ram_we_raw = 1'b0;
        ram_idx    = addr[ADDR_W+1:2];
        ram_din    = wdata;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (acc_err) begin
                        state_next = ST_RESP;
                    end else if (!mem_write) begin
                        state_next = ST_LD;
                    end else if (dm_type == DM_WORD) begin
                        ram_we_raw = 1'b1;
                        state_next = ST_RESP;
                    end else begin
                        state_next = ST_RMW;
                    end
                end
            end
            ST_LD: begin
                state_next = ST_RESP;
            end
            ST_RMW: begin
                ram_idx    = req_idx_q;
                ram_din    = store_merge(ram_dout, req_wdata_q, req_type_q, req_off_q);
                ram_we_raw = 1'b1;
                state_next = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid  = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Request capture and response data. Response registers only change on
    // the edge that enters RESP, so they hold between responses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            req_type_q  <= DM_WORD;
            req_off_q   <= 2'b00;
            req_idx_q   <= '0;
            req_wdata_q <= 16'h0000;
            rsp_rdata   <= 32'h0000_0000;
            rsp_err     <= 1'b0;
        end else begin
            if (accept) begin
                req_type_q  <= dm_type;
                req_off_q   <= addr[1:0];
                req_idx_q   <= addr[ADDR_W+1:2];
                req_wdata_q <= wdata[15:0];
                if (acc_err) begin
                    rsp_err   <= 1'b1;
                    rsp_rdata <= 32'h0000_0000;
                end else if (mem_write && dm_type == DM_WORD) begin
                    rsp_err   <= 1'b0;
                    rsp_rdata <= 32'h0000_0000;
                end
            end
            if (state == ST_LD) begin
                rsp_err   <= 1'b0;
                rsp_rdata <= load_extend(ram_dout, req_type_q, req_off_q);
            end
            if (state == ST_RMW) begin
                rsp_err   <= 1'b0;
                rsp_rdata <= 32'h0000_0000;
            end
        end
    end

endmodule

// File: tb/tb_dm_access_unit.sv
module tb_dm_access_unit;

    logic        clk;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic        mem_write;
    logic [2:0]  dm_type;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int          vectors;
    int          miscompares;
    logic [31:0] model_mem [128];
    logic [31:0] last_rdata;

    dm_access_unit #(.ADDR_W(7)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .mem_write (mem_write),
        .dm_type   (dm_type),
        .addr      (addr),
        .wdata     (wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic int ref_index(input logic [31:0] a);
        return int'((a / 4) % 128);
    endfunction

    function automatic logic ref_err(input logic [2:0] ty, input logic [31:0] a);
        if (ty > 3'd4) return 1'b1;
        if (ty == 3'd0 && (a % 4) != 0) return 1'b1;
        if ((ty == 3'd1 || ty == 3'd2) && (a % 2) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] ty, input logic [31:0] a);
        logic [31:0] v;
        if (ty == 3'd1 || ty == 3'd2) begin
            v = (w >> (16 * ((a % 4) / 2))) & 32'h0000_FFFF;
            if (ty == 3'd1 && v >= 32'd32768) v = v + 32'hFFFF_0000;
        end else if (ty == 3'd3 || ty == 3'd4) begin
            v = (w >> (8 * (a % 4))) & 32'h0000_00FF;
            if (ty == 3'd3 && v >= 32'd128) v = v + 32'hFFFF_FF00;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [2:0] ty,
                                              input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] mask;
        int          sh;
        if (ty == 3'd0) return wd;
        if (ty == 3'd1 || ty == 3'd2) begin
            sh   = 16 * int'((a % 4) / 2);
            mask = 32'h0000_FFFF << sh;
        end else begin
            sh   = 8 * int'(a % 4);
            mask = 32'h0000_00FF << sh;
        end
        return (w & ~mask) | ((wd << sh) & mask);
    endfunction

    // One complete access: wait for ready, present the request for one cycle,
    // then check latency, response contents and the return to idle.
    task automatic apply_stimulus(input logic wr, input logic [2:0] ty,
                                  input logic [31:0] a, input logic [31:0] wd, input string tag);
        logic        e_err;
        logic [31:0] e_rdata;
        int          e_lat;
        int          lat;
        int          guard;
        int          idx;
        idx     = ref_index(a);
        e_err   = ref_err(ty, a);
        e_rdata = (wr || e_err) ? 32'h0 : ref_load(model_mem[idx], ty, a);
        e_lat   = (e_err || (wr && ty == 3'd0)) ? 1 : 2;

        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check_output({tag, "_ready_wait"}, 32'(req_ready), 32'd1);

        req_valid = 1'b1;
        mem_write = wr;
        dm_type   = ty;
        addr      = a;
        wdata     = wd;
        @(negedge clk);
        req_valid = 1'b0;
        mem_write = $urandom_range(0, 1);
        dm_type   = 3'($urandom);
        addr      = $urandom;
        wdata     = $urandom;

        lat = 1;
        while (!rsp_valid && lat < 8) begin
            check_output({tag, "_busy_ready"}, 32'(req_ready), 32'd0);
            @(negedge clk);
            lat++;
        end
        check_output({tag, "_latency"}, 32'(lat), 32'(e_lat));
        check_output({tag, "_ready_in_resp"}, 32'(req_ready), 32'd0);
        check_output({tag, "_rdata"}, rsp_rdata, e_rdata);
        check_output({tag, "_err"}, 32'(rsp_err), 32'(e_err));
        last_rdata = rsp_rdata;

        if (wr && !e_err) model_mem[idx] = ref_store(model_mem[idx], ty, a, wd);

        @(negedge clk);
        check_output({tag, "_valid_pulse"}, 32'(rsp_valid), 32'd0);
        check_output({tag, "_ready_after"}, 32'(req_ready), 32'd1);
        check_output({tag, "_rdata_hold"}, rsp_rdata, e_rdata);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        last_rdata  = 32'h0;
        rstn        = 1'b0;
        req_valid   = 1'b0;
        mem_write   = 1'b0;
        dm_type     = 3'b000;
        addr        = 32'h0;
        wdata       = 32'h0;

        repeat (2) @(negedge clk);
        check_output("reset_ready", 32'(req_ready), 32'd1);
        check_output("reset_valid", 32'(rsp_valid), 32'd0);
        check_output("reset_rdata", rsp_rdata, 32'h0);
        check_output("reset_err", 32'(rsp_err), 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Give every RAM word a known value so the model tracks it exactly.
        for (int i = 0; i < 128; i++) apply_stimulus(1'b1, 3'd0, 32'(i * 4), $urandom, "fill");

        // Word store / load.
        apply_stimulus(1'b1, 3'd0, 32'h10, 32'hDEADBEEF, "sw_10");
        apply_stimulus(1'b0, 3'd0, 32'h10, 32'h0, "lw_10");
        check_output("lw_10_const", last_rdata, 32'hDEADBEEF);

        // Signed and unsigned sub-word loads.
        apply_stimulus(1'b1, 3'd0, 32'h20, 32'h80FF7F01, "sw_20");
        apply_stimulus(1'b0, 3'd3, 32'h23, 32'h0, "lb_23");
        check_output("lb_23_const", last_rdata, 32'hFFFFFF80);
        apply_stimulus(1'b0, 3'd4, 32'h23, 32'h0, "lbu_23");
        check_output("lbu_23_const", last_rdata, 32'h00000080);
        apply_stimulus(1'b0, 3'd3, 32'h20, 32'h0, "lb_20");
        check_output("lb_20_const", last_rdata, 32'h00000001);
        apply_stimulus(1'b0, 3'd1, 32'h22, 32'h0, "lh_22");
        check_output("lh_22_const", last_rdata, 32'hFFFF80FF);
        apply_stimulus(1'b0, 3'd2, 32'h22, 32'h0, "lhu_22");
        check_output("lhu_22_const", last_rdata, 32'h000080FF);

        // Read-modify-write stores.
        apply_stimulus(1'b1, 3'd0, 32'h30, 32'h11223344, "sw_30");
        apply_stimulus(1'b1, 3'd3, 32'h31, 32'hAAAAAA55, "sb_31");
        apply_stimulus(1'b0, 3'd0, 32'h30, 32'h0, "lw_30a");
        check_output("sb_31_const", last_rdata, 32'h11225544);
        apply_stimulus(1'b1, 3'd1, 32'h32, 32'h0000BEEF, "sh_32");
        apply_stimulus(1'b0, 3'd0, 32'h30, 32'h0, "lw_30b");
        check_output("sh_32_const", last_rdata, 32'hBEEF5544);

        // Error cases leave the RAM alone.
        apply_stimulus(1'b1, 3'd0, 32'h40, 32'hCAFEF00D, "sw_40");
        apply_stimulus(1'b0, 3'd0, 32'h42, 32'h0, "lw_42_err");
        apply_stimulus(1'b0, 3'd1, 32'h41, 32'h0, "lh_41_err");
        apply_stimulus(1'b0, 3'd7, 32'h40, 32'h0, "ty7_err");
        apply_stimulus(1'b1, 3'd0, 32'h42, 32'h01010101, "sw_42_err");
        apply_stimulus(1'b1, 3'd6, 32'h40, 32'h02020202, "st_ty6_err");
        apply_stimulus(1'b0, 3'd0, 32'h40, 32'h0, "lw_40");
        check_output("err_word_kept", last_rdata, 32'hCAFEF00D);

        // Address wrap: 0x200 aliases word 0.
        apply_stimulus(1'b1, 3'd0, 32'h200, 32'h5A5AA5A5, "sw_200");
        apply_stimulus(1'b0, 3'd0, 32'h000, 32'h0, "lw_000");
        check_output("wrap_const", last_rdata, 32'h5A5AA5A5);

        // req_valid held high: one accept every three cycles for loads.
        apply_stimulus(1'b1, 3'd0, 32'h60, 32'h600DCAFE, "sw_60");
        req_valid = 1'b1;
        mem_write = 1'b0;
        dm_type   = 3'd0;
        addr      = 32'h60;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check_output("hold_ready", 32'(req_ready), 32'((k % 3) == 2));
            check_output("hold_valid", 32'(rsp_valid), 32'((k % 3) == 1));
            if ((k % 3) == 1) check_output("hold_rdata", rsp_rdata, model_mem[ref_index(32'h60)]);
        end
        req_valid = 1'b0;

        // Reset during RMW abandons the write and the response.
        apply_stimulus(1'b1, 3'd0, 32'h50, 32'h12345678, "sw_50");
        apply_stimulus(1'b0, 3'd0, 32'h50, 32'h0, "lw_50a");
        req_valid = 1'b1;
        mem_write = 1'b1;
        dm_type   = 3'd3;
        addr      = 32'h50;
        wdata     = 32'h000000FF;
        @(negedge clk);
        req_valid = 1'b0;
        check_output("rmw_busy", 32'(req_ready), 32'd0);
        rstn = 1'b0;
        #1;
        check_output("abort_ready", 32'(req_ready), 32'd1);
        check_output("abort_valid", 32'(rsp_valid), 32'd0);
        check_output("abort_rdata", rsp_rdata, 32'h0);
        check_output("abort_err", 32'(rsp_err), 32'd0);
        repeat (2) begin
            @(negedge clk);
            check_output("abort_valid_rst", 32'(rsp_valid), 32'd0);
        end
        rstn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_output("abort_valid_post", 32'(rsp_valid), 32'd0);
        end
        apply_stimulus(1'b0, 3'd0, 32'h50, 32'h0, "lw_50b");
        check_output("abort_word_kept", last_rdata, 32'h12345678);

        // Random mix of loads/stores, all types and alignments, wrapping addresses.
        for (int n = 0; n < 80; n++) begin
            logic [31:0] ra;
            ra = $urandom;
            if ($urandom_range(0, 1) == 1) ra = ra & 32'h0000_01FC | 32'($urandom_range(0, 3));
            apply_stimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, $urandom, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

endmodule
